// File: rtl/modem_pkg.sv
// Shared definitions for the modem datapath rate bridge.
//   fsm_state_e : sequencing states of the bridge (IDLE, FILL, RUN)
//   clog2       : constant ceil(log2) used to size pointers and counters
package modem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } fsm_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO storage for the rate bridge.
//   clk, rstn : clock, async active-low reset
//   push, pop : write / read strobes; caller never pops empty and only
//               pushes into a full FIFO together with a pop
//   flush     : synchronous clear of pointers and level (storage untouched)
//   din, dout : write data, head-of-queue data (combinational)
//   level     : occupancy 0..depth
//   full/empty: occupancy flags
module sync_fifo_core import modem_pkg::*; #(
  parameter int width = 32,
  parameter int depth = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [width-1:0]       din,
  output logic [width-1:0]       dout,
  output logic [clog2(depth):0]  level,
  output logic                   full,
  output logic                   empty
);

  localparam int aw = clog2(depth);
  localparam logic [aw:0] full_lvl = (aw+1)'(depth);

  logic [width-1:0] mem_q [depth];
  logic [aw-1:0]    wr_ptr_q;
  logic [aw-1:0]    rd_ptr_q;
  logic [aw:0]      level_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage is not reset; level/pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign level = level_q;
  assign full  = (level_q == full_lvl);
  assign empty = (level_q == '0);

endmodule

// File: rtl/rate_bridge_fifo.sv
// Sample-rate bridge: accepts packed multi-channel words on an irregular
// valid strobe and emits them one every div+1 cycles once primed.
//   clk, rstn  : clock, async active-low reset
//   en         : block enable, 0 = idle and flush
//   div        : output period minus one
//   in_valid   : data_in qualifier
//   data_in    : packed samples, channel 0 in LSBs
//   data_out   : registered output word
//   out_stb    : data_out updated this cycle
//   level      : FIFO occupancy
//   ovf, udf   : sticky overflow / underflow flags
//   clr_flags  : clears ovf/udf (a same-cycle set wins)
module rate_bridge_fifo import modem_pkg::*; #(
  parameter int data_wdt = 16,
  parameter int n_ch     = 2,
  parameter int depth    = 8,
  parameter int div_wdt  = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       en,
  input  logic [div_wdt-1:0]         div,
  input  logic                       in_valid,
  input  logic [n_ch*data_wdt-1:0]   data_in,
  output logic [n_ch*data_wdt-1:0]   data_out,
  output logic                       out_stb,
  output logic [clog2(depth):0]      level,
  output logic                       ovf,
  output logic                       udf,
  input  logic                       clr_flags
);

  localparam int lw = clog2(depth) + 1;
  localparam logic [lw-1:0] half_lvl = lw'(depth / 2);

  logic [div_wdt-1:0]       cnt_q, cnt_d;
  fsm_state_e               state_q;
  logic [n_ch*data_wdt-1:0] data_out_q;
  logic                     out_stb_q, ovf_q, udf_q;

  logic                     tick, active, run_tick;
  logic                     push, pop, flush, ovf_set, udf_set;
  logic [n_ch*data_wdt-1:0] fifo_dout;
  logic [lw-1:0]            fifo_level;
  logic                     fifo_full, fifo_empty;

  always_comb begin
    // >= rather than == so that lowering div below the running count
    // wraps on the next cycle instead of counting through 2^div_wdt.
    tick     = en && (cnt_q >= div);
    cnt_d    = cnt_q + 1'b1;
    if (!en || tick) cnt_d = '0;
    active   = en && (state_q != ST_IDLE);
    run_tick = en && (state_q == ST_RUN) && tick;
    pop      = run_tick && !fifo_empty;
    udf_set  = run_tick && fifo_empty;
    // A full FIFO still takes a word when the same cycle pops one.
    push     = active && in_valid && (!fifo_full || pop);
    ovf_set  = active && in_valid && fifo_full && !pop;
    flush    = !en || (state_q == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      data_out_q <= '0;
      out_stb_q  <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      out_stb_q <= pop;
      if (pop) data_out_q <= fifo_dout;
      ovf_q <= ovf_set | (ovf_q & ~clr_flags);
      udf_q <= udf_set | (udf_q & ~clr_flags);
      if (!en) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_FILL;
          ST_FILL: if (fifo_level >= half_lvl) state_q <= ST_RUN;
          ST_RUN:  if (udf_set) state_q <= ST_FILL;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  sync_fifo_core #(
    .width (n_ch * data_wdt),
    .depth (depth)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (data_in),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign data_out = data_out_q;
  assign out_stb  = out_stb_q;
  assign level    = fifo_level;
  assign ovf      = ovf_q;
  assign udf      = udf_q;

endmodule

// File: doc/rate_bridge_fifo.md
Name: rate_bridge_fifo

Overview:
Single-clock sample-rate bridge for the modem datapath. It accepts multi-channel samples on an irregular valid strobe and emits them at a fixed programmable cadence (one output every div+1 cycles), buffering through a small FIFO. It generalises the divide-by-2 sampling register into an N-channel, depth-parametrised, ratio-programmable stage. It adds priming, overflow and underflow handling.

Parameters:
data_wdt, 16, bits per channel sample (signed)
n_ch, 2, channels packed per word (e.g. I/Q)
depth, 8, FIFO depth in words; power of 2, >=4
div_wdt, 8, width of the cadence divider register

Ports:
clk  input  1  single system clock, rising edge
rstn  input  1  asynchronous active-low reset
en  input  1  block enable; 0 = idle and flush
div  input  div_wdt  output period minus 1 (period = div+1 cycles)
in_valid  input  1  data_in qualifier, one word per cycle when high
data_in  input  n_ch*data_wdt  packed signed samples, channel 0 in LSBs
data_out  output  n_ch*data_wdt  registered packed samples
out_stb  output  1  one-cycle pulse: data_out updated this cycle
level  output  clog2(depth)+1  current FIFO occupancy, 0..depth
ovf  output  1  sticky: word dropped because FIFO full
udf  output  1  sticky: tick with empty FIFO while in RUN
clr_flags  input  1  synchronous clear of ovf/udf

Behaviour:
- Reset (rstn=0, async): data_out=0, out_stb=0, level=0, ovf=0, udf=0, divider=0, state=IDLE, pointers=0.
- Divider: cnt increments each cycle while en=1. When cnt>=div, tick=1 and cnt<=0. The >= compare makes a shrinking div wrap immediately. div=0 gives a tick every cycle. en=0 holds cnt at 0.
- FSM states: IDLE, FILL, RUN.
  - IDLE: entered on reset or whenever en=0 (en=0 overrides all states). Pointers and level are flushed to 0. data_out holds. When en=1, go to FILL next cycle.
  - FILL: writes are accepted; ticks produce no output. When level>=depth/2 at a clock edge, go to RUN.
  - RUN: on each tick with level>0, pop the head word into data_out and pulse out_stb the following edge (registered, latency 1 from tick). On a tick with level==0, set udf, do not pulse out_stb, hold data_out, and return to FILL.
- Write: in_valid=1 in FILL/RUN with level<depth writes data_in. If level==depth and no pop occurs in the same cycle, the word is dropped and ovf=1. If full with a simultaneous pop, the write is accepted and level is unchanged.
- Simultaneous push and pop with level>0: level unchanged. With level==0 there is no bypass; the pop counts as an underflow.
- Writes while in IDLE are ignored and do not set ovf.
- Pointers: clog2(depth) bits, natural wrap. level = wr_cnt - rd_cnt, kept as a separate counter.
- Flags: clr_flags=1 clears ovf/udf. A set condition in the same cycle wins, so the flag stays 1.
- Data is passed unmodified; no sign extension or arithmetic. Channel order is preserved.
- Minimum in-to-out latency: write edge → level reaches depth/2 → next tick → data_out on the following edge.

Decomposition:
- Shared package (modem_pkg): FSM state encoding (IDLE=2'd0, FILL=2'd1, RUN=2'd2) and a clog2 constant function.
- One sub-module, sync_fifo_core. It holds the storage array, read/write pointers and level counter. Its ports are push, pop, flush, din, dout, level, full and empty. It is single-clock with async active-low rstn.
- The top level holds the divider, FSM, output register and flags.

Test Plan:
- Reset and idle: rstn pulse mid-stream with 3 words queued → all outputs 0, level=0 immediately (async); after release with en=0, no out_stb.
- Priming and cadence: depth=8, div=3, push 4 words 0x0001..0x0004 (ch1=~ch0) back-to-back → no out_stb until level=4. Then out_stb every 4 cycles with words in order and channels unswapped.
- Underflow: after priming, stop in_valid → the 4 words come out, the 5th tick sets udf=1 with no out_stb and data_out held at word 4. State returns to FILL; 4 new pushes resume output.
- Overflow: div=15, push 10 words continuously → level saturates at 8, ovf=1, words 9 and 10 are dropped. A push coinciding with a tick while full is accepted and level stays 8.
- Flags and div change: clr_flags coinciding with a new overflow leaves ovf=1. Changing div from 7 to 1 while cnt=5 gives a tick on the next cycle, then a period of 2.
- en drop mid-RUN: deassert en with level=5 → level=0 next cycle, no out_stb. Re-enable re-enters FILL.
